mem_read_m1_ctrl: RTL and testbench

Read sequencer for the M1 operand buffer of the systolic array. On a start pulse it walks every (row, column) pair of the banked M1 BRAM in address order and drives the row/column/rd_en inputs of the M1 read-address skew stage. That stage delays lane x by x cycles. The sequencer waits for the last lane to drain before signalling completion. It supports downstream stall and a synchronous abort.

---
 rtl/mem_read_m1_ctrl.sv | 113 +++++++++++
 tb/tb_mem_read_m1_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_m1_ctrl.sv
// Read sequencer for the M1 operand buffer: walks (row, column) in address order,
// then waits N-1 cycles for the lane skew to drain. Optional tile_done via MEM_READ_M1_CTRL_TILE_DONE_EN.
module mem_read_m1_ctrl #(
   parameter int N = 3,
   parameter int M = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     stall,
   input  logic                     abort,
   output logic [$clog2(M)-1:0]     row,
   output logic [$clog2(M/N)-1:0]   column,
   output logic                     rd_en,
   output logic                     busy,
   output logic                     done
`ifdef MEM_READ_M1_CTRL_TILE_DONE_EN
   ,
   output logic                     tile_done
`endif
);

   localparam int RW = $clog2(M);
   localparam int CW = $clog2(M/N);
   localparam int DW = (N > 2) ? $clog2(N-1) : 1;
   localparam logic [RW-1:0] ROW_LAST   = RW'(M-1);
   localparam logic [CW-1:0] COL_LAST   = CW'(M/N-1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'((N > 1) ? N-2 : 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic [DW-1:0] drain_q, drain_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      drain_d = drain_q;
      rd_en   = (state_q == S_ISSUE) & ~stall & ~abort;
      busy    = (state_q == S_ISSUE) | (state_q == S_DRAIN);
      done    = (state_q == S_DONE);
      if (abort) begin
         state_d = S_IDLE;
         row_d   = '0;
         col_d   = '0;
         drain_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) state_d = S_ISSUE;
            end
            S_ISSUE: begin
               if (rd_en) begin
                  if (row_q == ROW_LAST) begin
                     row_d = '0;
                     if (col_q == COL_LAST) begin
                        // Final pair: counters already back at 0 for the next run.
                        col_d   = '0;
                        drain_d = '0;
                        state_d = (N == 1) ? S_DONE : S_DRAIN;
                     end else begin
                        col_d = col_q + 1'b1;
                     end
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (drain_q == DRAIN_LAST) begin
                  drain_d = '0;
                  state_d = S_DONE;
               end else begin
                  drain_d = drain_q + 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign row    = row_q;
   assign column = col_q;

`ifdef MEM_READ_M1_CTRL_TILE_DONE_EN
   assign tile_done = rd_en & (row_q == ROW_LAST);
`endif

endmodule

// File: tb/tb_mem_read_m1_ctrl.sv
// Bench for mem_read_m1_ctrl: two instances (N=3,M=6 and N=1,M=4) driven in parallel,
// checked every cycle against an issue-count model plus directed timing checks.
module tb_mem_read_m1_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic abort = 1'b0;

  always #5 clk = ~clk;

  logic [2:0] row0;
  logic [0:0] col0;
  logic       rd0, busy0, done0;
  logic [1:0] row1;
  logic [1:0] col1;
  logic       rd1, busy1, done1;
`ifdef MEM_READ_M1_CTRL_TILE_DONE_EN
  logic       td0, td1;
`endif

  mem_read_m1_ctrl #(.N(3), .M(6)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .abort(abort),
    .row(row0), .column(col0), .rd_en(rd0), .busy(busy0), .done(done0)
`ifdef MEM_READ_M1_CTRL_TILE_DONE_EN
    , .tile_done(td0)
`endif
  );

  mem_read_m1_ctrl #(.N(1), .M(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .abort(abort),
    .row(row1), .column(col1), .rd_en(rd1), .busy(busy1), .done(done1)
`ifdef MEM_READ_M1_CTRL_TILE_DONE_EN
    , .tile_done(td1)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a run is "issued addresses so far" plus "cycles since the last issue".
  int mn[2] = '{3, 1};
  int mm[2] = '{6, 4};
  int act[2];
  int iss[2];
  int tail[2];
  int cyc = 0;
  int t0 = 0;
  int done_at[2];
  int n_iss[2];

  function automatic int tot(input int i);
    return mm[i] * (mm[i] / mn[i]);
  endfunction
  function automatic int e_rd(input int i);
    return int'(act[i] != 0 && iss[i] < tot(i) && !stall && !abort);
  endfunction
  function automatic int e_row(input int i);
    return iss[i] % mm[i];
  endfunction
  function automatic int e_col(input int i);
    return (iss[i] / mm[i]) % (mm[i] / mn[i]);
  endfunction
  function automatic int e_busy(input int i);
    return int'(act[i] != 0 && (iss[i] < tot(i) || tail[i] < mn[i]));
  endfunction
  function automatic int e_done(input int i);
    return int'(act[i] != 0 && iss[i] == tot(i) && tail[i] == mn[i]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; iss[i] = 0; tail[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || abort) begin
        act[i] = 0; iss[i] = 0; tail[i] = 0;
      end else if (act[i] == 0) begin
        if (start) act[i] = 1;
      end else if (iss[i] < tot(i)) begin
        if (!stall) begin
          iss[i]++;
          if (iss[i] == tot(i)) tail[i] = 1;
        end
      end else if (tail[i] < mn[i]) begin
        tail[i]++;
      end else begin
        act[i] = 0; iss[i] = 0; tail[i] = 0;
      end
    end
  end

  // Scoreboard: every cycle, both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_en0", rd0, e_rd(0));
      check("row0", row0, e_row(0));
      check("col0", col0, e_col(0));
      check("busy0", busy0, e_busy(0));
      check("done0", done0, e_done(0));
      check("rd_en1", rd1, e_rd(1));
      check("row1", row1, e_row(1));
      check("col1", col1, e_col(1));
      check("busy1", busy1, e_busy(1));
      check("done1", done1, e_done(1));
`ifdef MEM_READ_M1_CTRL_TILE_DONE_EN
      check("tile_done0", td0, int'(e_rd(0) != 0 && e_row(0) == mm[0]-1));
      check("tile_done1", td1, int'(e_rd(1) != 0 && e_row(1) == mm[1]-1));
`endif
      if (done0 && done_at[0] < 0) done_at[0] = cyc - t0;
      if (done1 && done_at[1] < 0) done_at[1] = cyc - t0;
      if (rd0) n_iss[0]++;
      if (rd1) n_iss[1]++;
    end
  end

  task automatic run(input int ncyc, input int sa, input int sb, input int ab,
                     input int st2, input bit hold);
    t0 = cyc;
    done_at = '{-1, -1};
    n_iss = '{0, 0};
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (c == st2) || hold;
      stall = (c == sa) || (c == sb);
      abort = (c == ab);
      @(posedge clk); #1;
    end
    start = 1'b0; stall = 1'b0; abort = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd0"}, rd0, 0);
    check({tag, "_busy0"}, busy0, 0);
    check({tag, "_done0"}, done0, 0);
    check({tag, "_row0"}, row0, 0);
    check({tag, "_col0"}, col0, 0);
    check({tag, "_rd1"}, rd1, 0);
    check({tag, "_busy1"}, busy1, 0);
  endtask

  initial begin
    model_clear();
    done_at = '{-1, -1};
    n_iss = '{0, 0};
    #12;
    check_reset_outputs("reset");
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    run(20, -1, -1, -1, -1, 1'b0);
    check("plain_done_cyc0", done_at[0], 15);
    check("plain_issues0", n_iss[0], 12);
    check("plain_done_cyc1", done_at[1], 17);
    check("plain_issues1", n_iss[1], 16);

    run(22, 4, 5, -1, -1, 1'b0);
    check("stall_done_cyc0", done_at[0], 17);
    check("stall_issues0", n_iss[0], 12);
    check("stall_done_cyc1", done_at[1], 19);

    run(30, -1, -1, 7, 9, 1'b0);
    check("abort_done_cyc0", done_at[0], 24);
    check("abort_issues0", n_iss[0], 18);
    check("abort_done_cyc1", done_at[1], 26);

    run(40, -1, -1, -1, -1, 1'b1);
    check("hold_done_cyc0", done_at[0], 15);
    run(25, -1, -1, -1, 100, 1'b0);

    run(6, -1, -1, -1, -1, 1'b0);
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run(20, -1, -1, -1, -1, 1'b0);
    check("rerun_done_cyc0", done_at[0], 15);
    check("rerun_issues0", n_iss[0], 12);

    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 40) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0; stall = 1'b0; abort = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
